// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmit framer and the receiver:
//   - uart_state_e : frame sequencing states
//   - PARITY_*     : parity mode encodings for the PARITY parameter
//   - UART_*_LEVEL : line levels for idle/stop and start bits
//   - parity_bit() : parity of a data word (up to 9 bits) for a given mode
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    // Callers zero-extend narrower words; padding zeros do not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
        logic p;
        p = 1'b0;
        case (mode)
            PARITY_EVEN: p = ^data;
            PARITY_ODD:  p = ~(^data);
            default:     p = 1'b0;
        endcase
        return p;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmit framer. Accepts one word per frame over a valid/ready
// handshake and serialises it as: start bit, data LSB first, optional parity,
// then STOP_BITS stop bits. Every bit boundary is driven by baud_tick_in,
// which comes from the upstream baud tick stage.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   baud_tick_in  one-cycle pulse per bit period
//   tx_data_in    word to transmit, sampled on accept
//   tx_valid_in   upstream has a word
//   tx_ready_out  framer can accept a word (high only in IDLE)
//   tx_out        registered serial line, idle high
//   busy_out      frame pending or in progress (~tx_ready_out)
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick_in,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 tx_valid_in,
    output logic                 tx_ready_out,
    output logic                 tx_out,
    output logic                 busy_out
);

    localparam int unsigned      IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS=%0d outside 5..9", DATA_BITS);
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY=%0d is not 0, 1 or 2", PARITY);
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS=%0d is not 1 or 2", STOP_BITS);
    end

    uart_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;

    logic                 accept;
    logic [IDX_W-1:0]     idx_inc;

    assign accept  = tx_valid_in && (state_q == IDLE);
    assign idx_inc = idx_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        stop_cnt_d = stop_cnt_q;
        data_d     = data_q;
        par_d      = par_q;
        tx_d       = tx_q;

        case (state_q)
            // Ticks are ignored here, so a tick coincident with an accept
            // only arms the frame; the start bit waits for the next tick.
            IDLE: begin
                if (accept) begin
                    data_d  = tx_data_in;
                    par_d   = parity_bit(9'(tx_data_in), PARITY);
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (baud_tick_in) begin
                    tx_d    = UART_START_LEVEL;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick_in) begin
                    tx_d    = data_q[0];
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick_in) begin
                    if (idx_q < IDX_LAST) begin
                        idx_d = idx_inc;
                        tx_d  = data_q[idx_inc];
                    end else if (PARITY != PARITY_NONE) begin
                        tx_d    = par_q;
                        state_d = PAR;
                    end else begin
                        tx_d       = UART_IDLE_LEVEL;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end
                end
            end
            PAR: begin
                if (baud_tick_in) begin
                    tx_d       = UART_IDLE_LEVEL;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            // The line is already at the stop level; each tick here ends one
            // stop bit, and the last one hands control back to IDLE.
            STOP: begin
                if (baud_tick_in) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = UART_IDLE_LEVEL;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            par_q      <= 1'b0;
            tx_q       <= UART_IDLE_LEVEL;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            stop_cnt_q <= stop_cnt_d;
            data_q     <= data_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_out       = tx_q;
    assign tx_ready_out = (state_q == IDLE);
    assign busy_out     = ~tx_ready_out;

endmodule : uart_tx_frame

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
// Four framers share the clock and baud tick (every 4 clk):
//   inst0: 8N1, inst1: 8E1, inst2: 8O1, inst3: 8N2.
// Stimulus pushes the expected line sequence of each accepted word into that
// instance's queue; a per-instance monitor pops one entry on every tick and
// compares tx_out/ready/busy just after the edge. Ticks with nothing queued
// must leave the line idle high.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int NI = 4;

    typedef struct packed {
        logic tx;
        logic rdy;
    } exp_t;

    function automatic int unsigned par_of(input int i);
        return (i == 1) ? 1 : (i == 2) ? 2 : 0;
    endfunction

    function automatic int unsigned stop_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    logic          clk;
    logic          tick;
    logic [NI-1:0] rst_v;
    logic [NI-1:0] valid_v;
    logic [NI-1:0] ready_v;
    logic [NI-1:0] tx_v;
    logic [NI-1:0] busy_v;
    logic [7:0]    data_v [NI];

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    function automatic exp_t mk(input logic tx, input logic rdy);
        exp_t e;
        e.tx  = tx;
        e.rdy = rdy;
        return e;
    endfunction

    function automatic void qpush(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int i);
        case (i)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    function automatic void qclear(input int i);
        case (i)
            0: q0.delete();
            1: q1.delete();
            2: q2.delete();
            default: q3.delete();
        endcase
    endfunction

    task automatic check_bits(input string name, input int inst,
                              input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got %b, expected %b",
                     name, inst, $time, act, exp);
        end
    endtask

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            uart_tx_frame #(
                .DATA_BITS (8),
                .PARITY    (par_of(g)),
                .STOP_BITS (stop_of(g))
            ) u_dut (
                .clk          (clk),
                .rst          (rst_v[g]),
                .baud_tick_in (tick),
                .tx_data_in   (data_v[g]),
                .tx_valid_in  (valid_v[g]),
                .tx_ready_out (ready_v[g]),
                .tx_out       (tx_v[g]),
                .busy_out     (busy_v[g])
            );

            initial begin : mon
                logic t;
                exp_t e;
                forever begin
                    @(posedge clk);
                    t = tick;
                    #1;
                    if (t) begin
                        if (qsize(g) > 0) begin
                            e = qpop(g);
                            check_bits("frame bit (tx,ready,busy)", g,
                                       {tx_v[g], ready_v[g], busy_v[g]},
                                       {e.tx, e.rdy, ~e.rdy});
                        end else begin
                            check_bits("idle line tx", g, {2'b00, tx_v[g]}, 3'b001);
                        end
                    end
                end
            end
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick changes on the falling edge and is high across exactly one rising edge.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input int inst, input logic [7:0] d, input logic par);
        qpush(inst, mk(1'b0, 1'b0));
        for (int i = 0; i < 8; i++) qpush(inst, mk(d[i], 1'b0));
        if (par_of(inst) != 0) qpush(inst, mk(par, 1'b0));
        for (int s = 0; s < int'(stop_of(inst)); s++) qpush(inst, mk(1'b1, 1'b0));
        qpush(inst, mk(1'b1, 1'b1));
    endtask

    // par is the hand-computed parity bit for the instance's mode.
    task automatic send(input int inst, input logic [7:0] d, input logic par,
                        input bit hold, input bit align);
        int n;
        @(negedge clk);
        #1;
        if (align) begin
            n = 0;
            while (tick !== 1'b1 && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        data_v[inst]  = d;
        valid_v[inst] = 1'b1;
        n = 0;
        while (ready_v[inst] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (ready_v[inst] !== 1'b1) begin
            check_bits("accept timeout", inst, 3'b000, 3'b001);
            valid_v[inst] = 1'b0;
            return;
        end
        @(posedge clk);
        #2;
        push_frame(inst, d, par);
        if (!hold) begin
            @(negedge clk);
            #1;
            valid_v[inst] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int inst);
        int n;
        n = 0;
        while ((qsize(inst) != 0 || ready_v[inst] !== 1'b1) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_bits("frame drained", inst, {2'b00, (qsize(inst) == 0)}, 3'b001);
    endtask

    initial begin
        int n;
        rst_v   = '1;
        valid_v = '0;
        for (int i = 0; i < NI; i++) data_v[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            check_bits("reset state (tx,ready,busy)", i,
                       {tx_v[i], ready_v[i], busy_v[i]}, 3'b110);
        @(negedge clk);
        #1;
        rst_v = '0;

        // 8N1 0xA5: 0, 1,0,1,0,0,1,0,1, 1
        send(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        wait_idle(0);

        // Parity: even(0xA5)=0, odd(0xA5)=1, even(0x07)=1
        send(1, 8'hA5, 1'b0, 1'b0, 1'b0);
        wait_idle(1);
        send(2, 8'hA5, 1'b1, 1'b0, 1'b0);
        wait_idle(2);
        send(1, 8'h07, 1'b1, 1'b0, 1'b0);
        wait_idle(1);

        // Two stop bits
        send(3, 8'h00, 1'b0, 1'b0, 1'b0);
        wait_idle(3);

        // Back-to-back with valid held high
        send(0, 8'h00, 1'b0, 1'b1, 1'b0);
        send(0, 8'hFF, 1'b0, 1'b0, 1'b0);
        wait_idle(0);

        // Data change and valid pulse mid-frame are ignored
        send(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        #1;
        data_v[0]  = 8'hFF;
        valid_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        valid_v[0] = 1'b0;
        data_v[0]  = 8'h00;
        wait_idle(0);
        repeat (12) @(negedge clk);
        #1;

        // Accept coincident with a tick; start waits for the following tick
        send(0, 8'hC3, 1'b0, 1'b0, 1'b1);
        wait_idle(0);

        // Reset while data bit 3 is on the line (start + d0..d3 popped)
        send(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (qsize(0) > 6 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_bits("reached data bit 3", 0, {2'b00, (qsize(0) == 6)}, 3'b001);
        rst_v[0] = 1'b1;
        qclear(0);
        @(posedge clk);
        #1;
        check_bits("reset abort (tx,ready,busy)", 0,
                   {tx_v[0], ready_v[0], busy_v[0]}, 3'b110);
        @(negedge clk);
        #1;
        rst_v[0] = 1'b0;
        repeat (8) @(negedge clk);
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        wait_idle(0);

        repeat (8) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_frame
